// File: rtl/pong_sound_if.sv
// Signal bundle between the pong controller/raster and the sound generator.
// Names follow the controller's existing port names.
interface pong_sound_if;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       hit;
    logic [2:0] scoreLeft;
    logic [2:0] scoreRight;
    logic       speaker;
    logic       busy;
    logic [1:0] tone_id;

    modport master (
        output CounterX, CounterY, hit, scoreLeft, scoreRight,
        input  speaker, busy, tone_id
    );

    modport slave (
        input  CounterX, CounterY, hit, scoreLeft, scoreRight,
        output speaker, busy, tone_id
    );
endinterface

// File: rtl/pong_sound.sv
// Square-wave sound effects for pong: hit blip, score tone and a four-segment
// win jingle, with durations counted in raster frames.
//
// state | meaning
// IDLE  | silent, speaker held low
// HIT   | paddle-hit tone
// SCORE | score tone
// WIN   | win jingle, four alternating-pitch segments
module pong_sound #(
    parameter int HIT_HALF_PERIOD   = 28409,
    parameter int SCORE_HALF_PERIOD = 56818,
    parameter int HIT_FRAMES        = 3,
    parameter int SCORE_FRAMES      = 20,
    parameter int WIN_SEG_FRAMES    = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    pong_sound_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIT   = 2'd1,
        SCORE = 2'd2,
        WIN   = 2'd3
    } state_t;

    localparam logic [16:0] HIT_HM1   = 17'(HIT_HALF_PERIOD - 1);
    localparam logic [16:0] SCORE_HM1 = 17'(SCORE_HALF_PERIOD - 1);
    localparam logic [7:0]  HIT_F     = 8'(HIT_FRAMES);
    localparam logic [7:0]  SCORE_F   = 8'(SCORE_FRAMES);
    localparam logic [7:0]  WIN_F     = 8'(WIN_SEG_FRAMES);

    state_t      state, state_nx, ev_state;
    logic        tick;
    logic        armed;
    logic        prev_hit;
    logic [2:0]  prev_left, prev_right;
    logic [7:0]  frames_left, frames_nx;
    logic [1:0]  seg, seg_nx;
    logic [16:0] tone_cnt, tone_nx, half_m1;
    logic        spk, spk_nx;
    logic        ev_hit, ev_score, ev_win;

    always_comb begin
        ev_hit   = armed & bus.hit & ~prev_hit;
        ev_win   = armed & (bus.scoreLeft == 3'd0) & (bus.scoreRight == 3'd0)
                 & ((prev_left == 3'd7) | (prev_right == 3'd7));
        ev_score = armed & ((bus.scoreLeft != prev_left) | (bus.scoreRight != prev_right))
                 & ~ev_win;
        ev_state = IDLE;
        if (ev_win)
            ev_state = WIN;
        else if (ev_score)
            ev_state = SCORE;
        else if (ev_hit)
            ev_state = HIT;
    end

    // Win segments alternate pitch: even segments use the hit tone.
    always_comb begin
        half_m1 = HIT_HM1;
        case (state)
            SCORE:   half_m1 = SCORE_HM1;
            WIN:     half_m1 = seg[0] ? SCORE_HM1 : HIT_HM1;
            default: half_m1 = HIT_HM1;
        endcase
    end

    // Encoding doubles as priority, so ">=" implements enter-or-restart.
    always_comb begin
        state_nx  = state;
        frames_nx = frames_left;
        seg_nx    = seg;
        tone_nx   = tone_cnt;
        spk_nx    = spk;
        if (ev_state != IDLE && ev_state >= state) begin
            state_nx = ev_state;
            seg_nx   = 2'd0;
            tone_nx  = 17'd0;
            spk_nx   = 1'b0;
            case (ev_state)
                HIT:     frames_nx = HIT_F;
                SCORE:   frames_nx = SCORE_F;
                default: frames_nx = WIN_F;
            endcase
        end else if (state == IDLE) begin
            tone_nx = 17'd0;
            spk_nx  = 1'b0;
        end else begin
            if (tone_cnt == half_m1) begin
                tone_nx = 17'd0;
                spk_nx  = ~spk;
            end else begin
                tone_nx = tone_cnt + 17'd1;
            end
            if (tick) begin
                frames_nx = frames_left - 8'd1;
                if (frames_left == 8'd1) begin
                    tone_nx = 17'd0;
                    spk_nx  = 1'b0;
                    if (state == WIN && seg != 2'd3) begin
                        seg_nx    = seg + 2'd1;
                        frames_nx = WIN_F;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tick        <= 1'b0;
            armed       <= 1'b0;
            prev_hit    <= 1'b0;
            prev_left   <= 3'd0;
            prev_right  <= 3'd0;
            frames_left <= 8'd0;
            seg         <= 2'd0;
            tone_cnt    <= 17'd0;
            spk         <= 1'b0;
        end else begin
            state       <= state_nx;
            tick        <= (bus.CounterY == 9'd500) && (bus.CounterX == 10'd0);
            armed       <= 1'b1;
            prev_hit    <= bus.hit;
            prev_left   <= bus.scoreLeft;
            prev_right  <= bus.scoreRight;
            frames_left <= frames_nx;
            seg         <= seg_nx;
            tone_cnt    <= tone_nx;
            spk         <= spk_nx;
        end
    end

    assign bus.speaker = spk;
    assign bus.busy    = (state != IDLE);
    assign bus.tone_id = state;

endmodule
